// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: FSM state encodings.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Operation bus of the scoreboarded register file: read, write and reservation ports.
interface regfile_sb_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
);
    logic             Ready;
    logic [AW-1:0]    ReadRegister1;
    logic [AW-1:0]    ReadRegister2;
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] ReadData2;
    logic             ReadBusy1;
    logic             ReadBusy2;
    logic [AW-1:0]    WriteRegister;
    logic [WIDTH-1:0] WriteData;
    logic             RegWrite;
    logic             Reserve;
    logic [AW-1:0]    ReserveRegister;
    logic             ReserveAck;
    logic [AW:0]      BusyCount;

    modport master (
        output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
               Reserve, ReserveRegister,
        input  Ready, ReadData1, ReadData2, ReadBusy1, ReadBusy2, ReserveAck, BusyCount
    );

    modport slave (
        input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
               Reserve, ReserveRegister,
        output Ready, ReadData1, ReadData2, ReadBusy1, ReadBusy2, ReserveAck, BusyCount
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit array tracking pending writes, the reservation handshake and the busy count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  state_e        state,
    input  logic [AW-1:0] clr_idx,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          rsv,
    input  logic [AW-1:0] rsv_addr,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic          rd_busy1,
    output logic          rd_busy2,
    output logic          rsv_ack,
    output logic [AW:0]   busy_count
);
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             run, wr_hit_rsv, set_ev, clr_ev, inc, dec;

    assign run = (state == RUN);

    // A reservation landing on the register being written wins over the write's clear.
    always_comb begin
        wr_hit_rsv = wr_en && (wr_addr == rsv_addr);
        rsv_ack    = run && rsv && ((rsv_addr == '0) || !busy_q[rsv_addr] || wr_hit_rsv);
        set_ev     = rsv_ack && (rsv_addr != '0) && !Reset;
        clr_ev     = wr_en && !Reset && !(set_ev && wr_hit_rsv);
        inc        = set_ev && !busy_q[rsv_addr];
        dec        = clr_ev && busy_q[wr_addr];
        busy_d     = busy_q;
        if (state == CLEAR) busy_d[clr_idx] = 1'b0;
        if (clr_ev)         busy_d[wr_addr] = 1'b0;
        if (set_ev)         busy_d[rsv_addr] = 1'b1;
        cnt_d = cnt_q;
        if (inc && !dec)      cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};
        else if (dec && !inc) cnt_d = cnt_q - {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge Clk) begin
        busy_q <= busy_d;
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign rd_busy1   = run && (rd_addr1 != '0) && busy_q[rd_addr1] &&
                        !(wr_en && (wr_addr == rd_addr1));
    assign rd_busy2   = run && (rd_addr2 != '0) && busy_q[rd_addr2] &&
                        !(wr_en && (wr_addr == rd_addr2));
    assign busy_count = cnt_q;
endmodule

// File: rtl/regfile_sb.sv
// Register file with write forwarding, per-register pending-write scoreboard and a
// sequential clear phase that zeroes storage one register per cycle after reset.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        Clk,
    input  logic        Reset,
    regfile_sb_if.slave bus
);
    state_e           state_q, state_d;
    logic [AW-1:0]    clr_idx_q, clr_idx_d;
    logic             run, clr_en, wr_fwd, wr_upd;
    logic [WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // The clear index wraps to zero on the same edge that leaves CLEAR.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == CLEAR) begin
            clr_idx_d = clr_idx_q + {{(AW-1){1'b0}}, 1'b1};
            if (clr_idx_q == {AW{1'b1}}) state_d = RUN;
        end
    end

    always_comb begin
        run       = (state_q == RUN);
        clr_en    = (state_q == CLEAR);
        bus.Ready = run;
    end

    assign wr_fwd = run && bus.RegWrite && (bus.WriteRegister != '0);
    assign wr_upd = wr_fwd && !Reset;

    assign regs[0] = '0;
    for (genvar i = 1; i < DEPTH; i++) begin : g_reg
        logic [WIDTH-1:0] r_q;
        always_ff @(posedge Clk) begin
            if (clr_en && (clr_idx_q == AW'(i)))                r_q <= '0;
            else if (wr_upd && (bus.WriteRegister == AW'(i)))    r_q <= bus.WriteData;
        end
        assign regs[i] = r_q;
    end

    always_comb begin
        bus.ReadData1 = '0;
        bus.ReadData2 = '0;
        if (run) begin
            bus.ReadData1 = (wr_fwd && (bus.ReadRegister1 == bus.WriteRegister)) ?
                            bus.WriteData : regs[bus.ReadRegister1];
            bus.ReadData2 = (wr_fwd && (bus.ReadRegister2 == bus.WriteRegister)) ?
                            bus.WriteData : regs[bus.ReadRegister2];
        end
    end

    regfile_scoreboard #(.DEPTH(DEPTH), .AW(AW)) u_sb (
        .Clk        (Clk),
        .Reset      (Reset),
        .state      (state_q),
        .clr_idx    (clr_idx_q),
        .wr_en      (wr_fwd),
        .wr_addr    (bus.WriteRegister),
        .rsv        (bus.Reserve),
        .rsv_addr   (bus.ReserveRegister),
        .rd_addr1   (bus.ReadRegister1),
        .rd_addr2   (bus.ReadRegister2),
        .rd_busy1   (bus.ReadBusy1),
        .rd_busy2   (bus.ReadBusy2),
        .rsv_ack    (bus.ReserveAck),
        .busy_count (bus.BusyCount)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected outputs per cycle, a monitor checks them.
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_sb_if #(.WIDTH(32), .DEPTH(32)) bus ();

    regfile_sb #(.WIDTH(32), .DEPTH(32)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        bit [6:0]    m;   // 0 rdy,1 d1,2 d2,3 b1,4 b2,5 ack,6 cnt
        logic        rdy;
        logic [31:0] d1, d2;
        logic        b1, b2, ack;
        logic [5:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    localparam bit [6:0] ALL = 7'h7F;

    task automatic chk(input string tag, input string f, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got %h expected %h", tag, f, act, exp);
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.m[0]) chk(e.tag, "Ready",      {31'd0, bus.Ready},     {31'd0, e.rdy});
            if (e.m[1]) chk(e.tag, "ReadData1",  bus.ReadData1,          e.d1);
            if (e.m[2]) chk(e.tag, "ReadData2",  bus.ReadData2,          e.d2);
            if (e.m[3]) chk(e.tag, "ReadBusy1",  {31'd0, bus.ReadBusy1}, {31'd0, e.b1});
            if (e.m[4]) chk(e.tag, "ReadBusy2",  {31'd0, bus.ReadBusy2}, {31'd0, e.b2});
            if (e.m[5]) chk(e.tag, "ReserveAck", {31'd0, bus.ReserveAck}, {31'd0, e.ack});
            if (e.m[6]) chk(e.tag, "BusyCount",  {26'd0, bus.BusyCount}, {26'd0, e.cnt});
        end
    end

    task automatic push_exp(input string tag, input bit [6:0] m, input logic rdy,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic b1, input logic b2, input logic ack,
                            input logic [5:0] cnt);
        exp_t e;
        e.tag = tag; e.m = m; e.rdy = rdy; e.d1 = d1; e.d2 = d2;
        e.b1 = b1; e.b2 = b2; e.ack = ack; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input logic rs,
                         input logic [4:0] ra);
        bus.ReadRegister1 = r1;  bus.ReadRegister2 = r2;
        bus.RegWrite = we;       bus.WriteRegister = wa;  bus.WriteData = wd;
        bus.Reserve = rs;        bus.ReserveRegister = ra;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        // Clear phase: writes and reservations must be ignored, outputs forced low
        for (int i = 0; i < 32; i++) begin
            drive(3, 4, 1, 3, 32'hA5A5A5A5, 1, 4);
            push_exp($sformatf("clear%0d", i), ALL, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drive(3, 4, 0, 0, 0, 0, 0);
        push_exp("run_entry", ALL, 1, 0, 0, 0, 0, 0, 0);
        tick();

        drive(5, 5, 1, 5, 32'hDEADBEEF, 0, 0);
        push_exp("fwd_same", ALL, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0);
        tick();
        drive(5, 0, 0, 0, 0, 0, 0);
        push_exp("fwd_next", ALL, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        tick();

        drive(7, 0, 0, 0, 0, 1, 7);
        push_exp("rsv7", ALL, 1, 0, 0, 0, 0, 1, 0);
        tick();
        drive(7, 0, 0, 0, 0, 1, 7);
        push_exp("rsv7_again", ALL, 1, 0, 0, 1, 0, 0, 1);
        tick();
        drive(7, 0, 1, 7, 32'h77, 0, 0);
        push_exp("wr7_fwd", ALL, 1, 32'h77, 0, 0, 0, 0, 1);
        tick();
        drive(7, 0, 0, 0, 0, 0, 0);
        push_exp("wr7_done", ALL, 1, 32'h77, 0, 0, 0, 0, 0);
        tick();

        drive(9, 0, 0, 0, 0, 1, 9);
        push_exp("rsv9", ALL, 1, 0, 0, 0, 0, 1, 0);
        tick();
        drive(9, 0, 1, 9, 32'h12, 1, 9);
        push_exp("wr_rsv9", ALL, 1, 32'h12, 0, 0, 0, 1, 1);
        tick();
        drive(9, 0, 0, 0, 0, 0, 0);
        push_exp("wr_rsv9_after", ALL, 1, 32'h12, 0, 1, 0, 0, 1);
        tick();

        drive(0, 0, 1, 0, 32'hFFFFFFFF, 1, 0);
        push_exp("r0_wr_rsv", ALL, 1, 0, 0, 0, 0, 1, 1);
        tick();
        drive(0, 9, 0, 0, 0, 0, 0);
        push_exp("r0_after", ALL, 1, 0, 32'h12, 0, 1, 0, 1);
        tick();

        drive(5, 9, 0, 0, 0, 1, 10);
        push_exp("rsv10", ALL, 1, 32'hDEADBEEF, 32'h12, 0, 1, 1, 1);
        tick();
        drive(10, 9, 0, 0, 0, 1, 11);
        push_exp("rsv11", ALL, 1, 0, 32'h12, 1, 1, 1, 2);
        tick();
        drive(10, 11, 0, 0, 0, 0, 0);
        push_exp("three_busy", ALL, 1, 0, 0, 1, 1, 0, 3);
        tick();

        // Reset mid-RUN with a competing write and reservation in the same cycle
        rst = 1'b1;
        drive(5, 9, 1, 5, 32'h55, 1, 12);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive(5, 9, 1, 5, 32'h55, 1, 12);
            push_exp($sformatf("reclear%0d", i), ALL, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        drive(5, 9, 0, 0, 0, 0, 0);
        push_exp("rerun", ALL, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(10, 12, 0, 0, 0, 0, 0);
        push_exp("rerun_busy", ALL, 1, 0, 0, 0, 0, 0, 0);
        tick();

        drive(3, 0, 1, 3, 32'h33, 0, 0);
        push_exp("wr_notbusy", ALL, 1, 32'h33, 0, 0, 0, 0, 0);
        tick();
        drive(3, 0, 0, 0, 0, 0, 0);
        push_exp("wr_notbusy_after", ALL, 1, 32'h33, 0, 0, 0, 0, 0);
        tick();

        tick();
        tick();
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d entries left expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
